// File: rtl/gate_seq_checker.sv
// gate_seq_checker
// Drives the four {a,b} input combinations (00, 01, 10, 11) onto a 2-input
// combinational gate. Each vector is held for SETTLE_CYCLES cycles, then the
// gate output is sampled and compared against TRUTH_TABLE[{a,b}]. The block
// reports per-vector failures, an error count and a pass flag.
//
// Parameters:
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//   TRUTH_TABLE   : expected gate_y, bit i for vector i (4'b1000 = AND)
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   run request, only looked at in IDLE
//   gate_a    out  gate input a (vector bit 1)
//   gate_b    out  gate input b (vector bit 0)
//   gate_y    in   gate output under test
//   busy      out  run in progress
//   done      out  one-cycle end-of-run pulse
//   pass      out  last completed run had no mismatches
//   err_count out  mismatching vectors in current/last run (0..4)
//   fail_vec  out  bit i set when vector i mismatched
//
// Optional feature macro: GATE_SEQ_STOP_ON_FAIL_EN. When it is defined, the
// first mismatch ends the run immediately.

module gate_seq_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_r, state_s;
    logic [1:0] vec_r, vec_s;
    logic [3:0] cnt_r, cnt_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic [2:0] err_r, err_s;
    logic [3:0] fail_r, fail_s;

    logic       mismatch_s;
    logic [2:0] err_upd_s;
    logic [3:0] fail_upd_s;
    logic       finish_s;

    // Compare the current vector's gate output and precompute updated tallies.
    assign mismatch_s = (gate_y != TRUTH_TABLE[vec_r]);
    assign err_upd_s  = err_r + {2'b00, mismatch_s};
    assign fail_upd_s = mismatch_s ? (fail_r | (4'b0001 << vec_r)) : fail_r;

    // The run ends after the last vector, or on the first mismatch when enabled.
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    assign finish_s = (vec_r == 2'd3) || mismatch_s;
`else
    assign finish_s = (vec_r == 2'd3);
`endif

    // Next-state and next-output logic. Outputs are computed one edge ahead so
    // that busy falls, done rises and pass becomes valid on the edge entering DONE.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        pass_s  = pass_r;
        err_s   = err_r;
        fail_s  = fail_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    vec_s   = 2'd0;
                    cnt_s   = 4'd0;
                    err_s   = 3'd0;
                    fail_s  = 4'd0;
                    pass_s  = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                err_s  = err_upd_s;
                fail_s = fail_upd_s;
                if (finish_s) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_upd_s == 3'd0);
                    state_s = ST_DONE;
                end else begin
                    vec_s   = vec_r + 2'd1;
                    cnt_s   = 4'd0;
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            vec_r   <= 2'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= 3'd0;
            fail_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            fail_r  <= fail_s;
        end
    end

    assign gate_a    = vec_r[1];
    assign gate_b    = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fail_r;

endmodule

// File: tb/tb_gate_seq_checker.sv
// Testbench for gate_seq_checker. Two lanes: lane 0 uses SETTLE_CYCLES=1 and
// lane 1 uses SETTLE_CYCLES=3, both with the AND truth table. Each lane has its
// own gate model, selected by mode: 0 = a&b, 1 = a|b, 2 = a&b delayed by two
// registers, 3 = stuck at 1. A timeline model per lane predicts every output on
// every cycle. Directed tests add hand-computed literal expectations.

module tb_gate_seq_checker;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start_v [2];
    int   mode_v  [2];
    logic ga_v    [2];
    logic gb_v    [2];
    logic y_v     [2];
    logic busy_v  [2];
    logic done_v  [2];
    logic pass_v  [2];
    logic [2:0] err_v  [2];
    logic [3:0] fail_v [2];

    wire [3:0] tt_w = 4'b1000;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int S = (g == 0) ? 1 : 3;
        logic d1, d2;

        gate_seq_checker #(.SETTLE_CYCLES(S), .TRUTH_TABLE(4'b1000)) dut (
            .clk(clk), .reset(reset), .start(start_v[g]),
            .gate_a(ga_v[g]), .gate_b(gb_v[g]), .gate_y(y_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]),
            .err_count(err_v[g]), .fail_vec(fail_v[g])
        );

        // Gate under test models.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                d1 <= 1'b0;
                d2 <= 1'b0;
            end else begin
                d1 <= ga_v[g] & gb_v[g];
                d2 <= d1;
            end
        end

        always_comb begin
            case (mode_v[g])
                0: y_v[g] = ga_v[g] & gb_v[g];
                1: y_v[g] = ga_v[g] | gb_v[g];
                2: y_v[g] = d2;
                default: y_v[g] = 1'b1;
            endcase
        end

        // Timeline model: k counts edges since start acceptance; a compare
        // happens whenever k is a multiple of S+1.
        int   m_k;
        int   m_err;
        logic [3:0] m_fail;
        logic [1:0] m_vec;
        logic m_busy, m_done, m_pass;

        always @(posedge clk or posedge reset) begin : model
            int   k2, v, e2;
            logic bad;
            logic [3:0] f2;
            if (reset) begin
                m_k <= 0; m_err <= 0; m_fail <= 4'd0; m_vec <= 2'd0;
                m_busy <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
            end else if (m_busy) begin
                k2 = m_k + 1;
                m_k <= k2;
                if (k2 % (S + 1) == 0) begin
                    v   = k2 / (S + 1) - 1;
                    bad = (y_v[g] != tt_w[v]);
                    e2  = m_err + (bad ? 1 : 0);
                    f2  = m_fail;
                    if (bad) f2[v] = 1'b1;
                    m_err  <= e2;
                    m_fail <= f2;
                    if (v == 3 || (STOP && bad)) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                        m_pass <= (e2 == 0);
                    end else begin
                        m_vec <= 2'(v + 1);
                    end
                end
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (start_v[g]) begin
                m_busy <= 1'b1; m_k <= 0; m_vec <= 2'd0;
                m_err <= 0; m_fail <= 4'd0; m_pass <= 1'b0;
            end
        end

        // Per-cycle comparison of every output against the model.
        always @(negedge clk) begin
            chk($sformatf("lane%0d busy", g), busy_v[g], m_busy);
            chk($sformatf("lane%0d done", g), done_v[g], m_done);
            chk($sformatf("lane%0d pass", g), pass_v[g], m_pass);
            chk($sformatf("lane%0d err_count", g), err_v[g], m_err);
            chk($sformatf("lane%0d fail_vec", g), fail_v[g], m_fail);
            chk($sformatf("lane%0d gate_ab", g), {ga_v[g], gb_v[g]}, m_vec);
        end
    end

    int hist [64];

    // Pulse start for one cycle, then count edges until done is seen.
    // hist[n] records {gate_a,gate_b} after edge n (edge 0 accepts start).
    task automatic run(input int ln, output int edges);
        start_v[ln] = 1'b1;
        @(negedge clk);
        start_v[ln] = 1'b0;
        hist[0] = {ga_v[ln], gb_v[ln]};
        edges = 0;
        while (!done_v[ln] && edges < 60) begin
            @(negedge clk);
            edges++;
            hist[edges] = {ga_v[ln], gb_v[ln]};
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input int ln, input string tag);
        chk({tag, " busy"}, busy_v[ln], 0);
        chk({tag, " done"}, done_v[ln], 0);
        chk({tag, " pass"}, pass_v[ln], 0);
        chk({tag, " err"}, err_v[ln], 0);
        chk({tag, " fail_vec"}, fail_v[ln], 0);
        chk({tag, " gate_a"}, ga_v[ln], 0);
        chk({tag, " gate_b"}, gb_v[ln], 0);
    endtask

    initial begin
        int n, dn;
        reset = 1'b1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        mode_v[0] = 0; mode_v[1] = 0;
        repeat (3) @(negedge clk);
        chk_zero(0, "rst lane0");
        chk_zero(1, "rst lane1");
        reset = 1'b0;
        @(negedge clk);

        // Test 1: AND, all pass.
        run(0, n);
        chk("t1 done edge", n, 8);
        chk("t1 vec e0", hist[0], 0);
        chk("t1 vec e2", hist[2], 1);
        chk("t1 vec e4", hist[4], 2);
        chk("t1 vec e6", hist[6], 3);
        chk("t1 pass", pass_v[0], 1);
        chk("t1 err", err_v[0], 0);
        chk("t1 fail_vec", fail_v[0], 0);

        // Test 2: wrong gate (OR against AND table).
        mode_v[0] = 1;
        run(0, n);
        chk("t2 pass", pass_v[0], 0);
        if (STOP) begin
            chk("t2 done edge", n, 4);
            chk("t2 err", err_v[0], 1);
            chk("t2 fail_vec", fail_v[0], 4'b0010);
        end else begin
            chk("t2 done edge", n, 8);
            chk("t2 err", err_v[0], 2);
            chk("t2 fail_vec", fail_v[0], 4'b0110);
        end

        // Test 3: starts at edges 3 and 8 are ignored; acceptance clears results.
        mode_v[0] = 0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("t3 cleared err", err_v[0], 0);
        chk("t3 cleared fail_vec", fail_v[0], 0);
        chk("t3 cleared pass", pass_v[0], 0);
        dn = 0;
        for (int j = 1; j <= 12; j++) begin
            start_v[0] = (j == 3 || j == 8);
            @(negedge clk);
            start_v[0] = 1'b0;
            if (done_v[0]) dn++;
        end
        chk("t3 done count", dn, 1);
        run(0, n);
        chk("t3 rerun done edge", n, 8);
        chk("t3 rerun pass", pass_v[0], 1);

        // Test 4: reset while vector 2 settles, then a clean full run.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4 vec before reset", {ga_v[0], gb_v[0]}, 2);
        #2 reset = 1'b1;
        #1 chk_zero(0, "t4 async reset");
        @(negedge clk);
        reset = 1'b0;
        run(0, n);
        chk("t4 restart vec", hist[0], 0);
        chk("t4 done edge", n, 8);
        chk("t4 pass", pass_v[0], 1);

        // Test 5: gate output delayed by two registers.
        mode_v[1] = 2;
        run(1, n);
        chk("t5 S3 done edge", n, 16);
        chk("t5 S3 pass", pass_v[1], 1);
        mode_v[0] = 2;
        run(0, n);
        chk("t5 S1 pass", pass_v[0], 0);
        chk("t5 S1 err nonzero", (err_v[0] >= 3'd1) ? 1 : 0, 1);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        // Test 6: stuck-at-1 output stops the run at the first vector.
        mode_v[0] = 3;
        run(0, n);
        chk("t6 done edge", n, 2);
        chk("t6 err", err_v[0], 1);
        chk("t6 fail_vec", fail_v[0], 4'b0001);
        chk("t6 pass", pass_v[0], 0);
        chk("t6 vec e1", hist[1], 0);
        chk("t6 vec e2", hist[2], 0);
        chk("t6 vec after", {ga_v[0], gb_v[0]}, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_seq_checker.md
# gate_seq_checker

Self-checking sequencer for a 2-input combinational gate under test (AND, OR, XOR, …).
- On a start pulse it drives all four input combinations onto the gate in a fixed order.
- It waits a programmable settle time per vector, samples the gate output and compares it with a parameterised truth table.
- It reports per-vector failures, an error count and a pass flag.
- It sits beside the gate models and replaces hand-written `#1`/`$display` stimulus with a synthesizable, cycle-accurate check.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `TRUTH_TABLE`, default 4'b1000: expected output indexed by {a,b}. Bit i is the expected `gate_y` for vector i. 4'b1000 = AND.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces all state and outputs to reset values immediately.
- `start` in 1: request a run; sampled only in IDLE.
- `gate_a` out 1: gate input a; reset 0.
- `gate_b` out 1: gate input b; reset 0.
- `gate_y` in 1: gate output under test.
- `busy` out 1: high from the start-accepting edge until DONE is entered; reset 0.
- `done` out 1: one-cycle pulse, high for the single DONE cycle; reset 0.
- `pass` out 1: 1 when the last completed run had err_count==0; cleared on start acceptance; reset 0.
- `err_count` out 3: number of mismatching vectors in the current/last run (0..4); reset 0.
- `fail_vec` out 4: bit i set if vector i mismatched; reset 0.

## Operation

- Vector index v (2 bits) maps to gate_a=v[1], gate_b=v[0].
- Application order is 0,1,2,3, i.e. {a,b} = 00, 01, 10, 11.

FSM states: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**, start=1: v←0, gate_a/gate_b←00, settle counter←0, err_count←0, fail_vec←0, pass←0, busy←1, go to SETTLE. If start=0, remain in IDLE.
- **SETTLE**: increment the settle counter. When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
- **SAMPLE**: compare gate_y with TRUTH_TABLE[v]. On mismatch: err_count←err_count+1 and fail_vec[v]←1.
  - If v==3: go to DONE.
  - Else: v←v+1, drive the new vector onto gate_a/gate_b on this same edge, settle counter←0, go to SETTLE.
- **DONE**: done=1, pass←(err_count==0), busy←0; next state IDLE.

Rules:
- err_count saturates at 4 by construction, since each vector is compared exactly once. No wrap.
- gate_a/gate_b hold the last applied vector after the run, until the next accepted start or reset.
- err_count, fail_vec and pass hold their values after DONE until the next accepted start or reset.
- start in SETTLE, SAMPLE or DONE is ignored; it is not queued.
- A start held high continuously starts a new run at every IDLE visit.

## Timing

- Let S = SETTLE_CYCLES, and call the edge that accepts start edge 0.
- Vector v is driven from edge v·(S+1) and compared at edge (v+1)·(S+1).
- Per-vector cost is S+1 cycles.
- done is high in the cycle following edge 4·(S+1). Example: S=1 gives edge 8.
- busy is high during cycles 1..4·(S+1). It falls on the same edge done rises.
- pass is valid from the DONE cycle onward.
- Reset asserted at any point returns all outputs to reset values asynchronously. The aborted run leaves no residue, and the next accepted start begins again at v=0.
- Reset deassertion plus start in the same cycle: start is accepted at the first rising edge with reset low.

## Configuration

- Macro: `GATE_SEQ_STOP_ON_FAIL_EN`.
- **Defined**: a mismatch in SAMPLE goes directly to DONE regardless of v. err_count is then 1, fail_vec has exactly one bit set, and the remaining vectors are not applied.
- **Undefined**: all four vectors are always applied and checked.

## Test plan

1. **AND, all pass.** S=1, TRUTH_TABLE=4'b1000, gate_y=a&b, one-cycle start pulse.
   - gate_a/gate_b go 00, 01, 10, 11 at edges 0, 2, 4, 6.
   - done pulses after edge 8; pass=1, err_count=0, fail_vec=4'b0000.
2. **Wrong gate.** Same parameters, gate_y=a|b.
   - err_count=2, fail_vec=4'b0110, pass=0, done after edge 8.
3. **Start handling and re-run.**
   - Pulse start again at edges 3 and 8 → ignored; exactly one done.
   - Then a start in IDLE clears err_count/fail_vec/pass, and a second done follows 8 edges later.
4. **Reset mid-run.** Assert reset while v=2 is in SETTLE.
   - All outputs go to 0 immediately and busy=0.
   - After release, start → vector 00 is applied again and the full run passes.
5. **Settle time.** gate_y = a&b delayed by 2 registered cycles.
   - S=3 → pass=1, done after edge 16.
   - S=1 → pass=0, err_count≥1.
6. **Stop-on-fail.** With `GATE_SEQ_STOP_ON_FAIL_EN` defined, S=1, AND table, gate_y stuck at 1.
   - done after edge 2; err_count=1, fail_vec=4'b0001, pass=0.
   - gate_a/gate_b never leave 00.
